// File: rtl/shop_cmd_seq.sv
// Scripted command sequencer for shop_v: replays admin login, add seller Us1 and delete Us1,
// and checks each settled response against the expected prompt.
module shop_cmd_seq #(
    parameter int unsigned I_A_NUM_ASCII_CHARS = 7,
    parameter int unsigned O_A_NUM_ASCII_CHARS = 9,
    parameter int unsigned I_U_NUM_BITS        = 4,
    parameter int unsigned SETUP_CYCLES        = 1,
    parameter int unsigned RESP_WAIT           = 4,
    parameter int unsigned STEP_GAP            = 1
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_start,
    input  logic [O_A_NUM_ASCII_CHARS*8-1:0] i_shop_a,
    output logic                             o_rdy,
    output logic [I_U_NUM_BITS-1:0]          o_u,
    output logic [I_A_NUM_ASCII_CHARS*8-1:0] o_a,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_pass,
    output logic [3:0]                       o_fail_step,
    output logic [3:0]                       o_step
);

    localparam int unsigned CmdW = I_A_NUM_ASCII_CHARS * 8;
    localparam int unsigned RspW = O_A_NUM_ASCII_CHARS * 8;
    localparam int unsigned CntW = 16;

    localparam logic [CntW-1:0] SetupLoad = CntW'(SETUP_CYCLES - 1);
    localparam logic [CntW-1:0] WaitLoad  = CntW'(RESP_WAIT - 1);
    localparam logic [CntW-1:0] GapLoad   = CntW'(STEP_GAP - 1);

    localparam logic [3:0] LastStep = 4'd8;
    localparam logic [3:0] NoFail   = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StWait,
        StCheck,
        StGap,
        StDone
    } state_e;

    // Command words are right-aligned with zero high bytes, as a string-literal assignment gives.
    function automatic logic [CmdW-1:0] cmd_word(input logic [3:0] step);
        logic [CmdW-1:0] w;
        w = '0;
        case (step)
            4'd0:    w = CmdW'("Login");
            4'd1:    w = CmdW'("Adm");
            4'd2:    w = CmdW'("123");
            4'd3:    w = CmdW'("AddUsr");
            4'd4:    w = CmdW'("Us1");
            4'd5:    w = CmdW'("Ps1");
            4'd6:    w = CmdW'("SELLER");
            4'd7:    w = CmdW'("DelUsr");
            4'd8:    w = CmdW'("Us1");
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic logic [RspW-1:0] rsp_word(input logic [3:0] step);
        logic [RspW-1:0] w;
        w = '0;
        case (step)
            4'd0:    w = RspW'("Username?");
            4'd1:    w = RspW'("Password?");
            4'd2:    w = RspW'("Cmd?");
            4'd3:    w = RspW'("Username?");
            4'd4:    w = RspW'("Password?");
            4'd5:    w = RspW'("Perms?");
            4'd6:    w = RspW'("Cmd?");
            4'd7:    w = RspW'("Username?");
            4'd8:    w = RspW'("Cmd?");
            default: w = '0;
        endcase
        return w;
    endfunction

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      step_q, step_d;
    logic [CmdW-1:0] cmd_q, cmd_d;
    logic            pass_q, pass_d;
    logic [3:0]      fail_q, fail_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            step_q  <= 4'd0;
            cmd_q   <= '0;
            pass_q  <= 1'b0;
            fail_q  <= NoFail;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            cmd_q   <= cmd_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        cmd_d   = cmd_q;
        pass_d  = pass_q;
        fail_d  = fail_q;

        case (state_q)
            StIdle, StDone: begin
                // Start is only honoured here; a restart from DONE clears the previous verdict.
                if (i_start) begin
                    state_d = StSetup;
                    cnt_d   = SetupLoad;
                    step_d  = 4'd0;
                    cmd_d   = cmd_word(4'd0);
                    pass_d  = 1'b0;
                    fail_d  = NoFail;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StStrobe;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStrobe: begin
                state_d = StWait;
                cnt_d   = WaitLoad;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StCheck: begin
                if (i_shop_a != rsp_word(step_q)) begin
                    state_d = StDone;
                    pass_d  = 1'b0;
                    fail_d  = step_q;
                end else if (step_q == LastStep) begin
                    state_d = StDone;
                    pass_d  = 1'b1;
                    fail_d  = NoFail;
                end else begin
                    state_d = StGap;
                    cnt_d   = GapLoad;
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StSetup;
                    cnt_d   = SetupLoad;
                    step_d  = step_q + 4'd1;
                    cmd_d   = cmd_word(step_q + 4'd1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset gates the strobe combinationally so shop_v never sees a command during reset.
    assign o_rdy       = (state_q == StStrobe) && !i_reset;
    assign o_u         = '0;
    assign o_a         = cmd_q;
    assign o_busy      = (state_q != StIdle) && (state_q != StDone);
    assign o_done      = (state_q == StDone);
    assign o_pass      = pass_q;
    assign o_fail_step = fail_q;
    assign o_step      = step_q;

endmodule

// File: tb/tb_shop_cmd_seq.sv
// Bench for shop_cmd_seq: directed table, randomized fault runs against a script-level model,
// reset and held-start sequences, plus a second instance with stretched timing.
module tb_shop_cmd_seq;

    localparam int AW = 56;
    localparam int RW = 72;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start_a, start_b, rsp_clr, sel;
    logic [RW-1:0] shop_a_a, shop_a_b;

    logic          rdy_a, busy_a, done_a, pass_a;
    logic [3:0]    u_a, fail_a, step_a;
    logic [AW-1:0] a_a;
    logic          rdy_b, busy_b, done_b, pass_b;
    logic [3:0]    u_b, fail_b, step_b;
    logic [AW-1:0] a_b;

    shop_cmd_seq dut_a (
        .i_clk(clk), .i_reset(rst), .i_start(start_a), .i_shop_a(shop_a_a),
        .o_rdy(rdy_a), .o_u(u_a), .o_a(a_a), .o_busy(busy_a), .o_done(done_a),
        .o_pass(pass_a), .o_fail_step(fail_a), .o_step(step_a)
    );

    shop_cmd_seq #(.SETUP_CYCLES(3), .RESP_WAIT(1), .STEP_GAP(2)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_start(start_b), .i_shop_a(shop_a_b),
        .o_rdy(rdy_b), .o_u(u_b), .o_a(a_b), .o_busy(busy_b), .o_done(done_b),
        .o_pass(pass_b), .o_fail_step(fail_b), .o_step(step_b)
    );

    logic          obs_rdy, obs_busy, obs_done, obs_pass;
    logic [3:0]    obs_u, obs_fail, obs_step;
    logic [AW-1:0] obs_a;
    assign obs_rdy  = sel ? rdy_b  : rdy_a;
    assign obs_busy = sel ? busy_b : busy_a;
    assign obs_done = sel ? done_b : done_a;
    assign obs_pass = sel ? pass_b : pass_a;
    assign obs_u    = sel ? u_b    : u_a;
    assign obs_fail = sel ? fail_b : fail_a;
    assign obs_step = sel ? step_b : step_a;
    assign obs_a    = sel ? a_b    : a_a;

    // Script as the shop_v protocol defines it.
    logic [AW-1:0] cmd_tab [9] = '{AW'("Login"), AW'("Adm"), AW'("123"), AW'("AddUsr"),
                                   AW'("Us1"), AW'("Ps1"), AW'("SELLER"), AW'("DelUsr"),
                                   AW'("Us1")};
    logic [RW-1:0] rsp_tab [9] = '{RW'("Username?"), RW'("Password?"), RW'("Cmd?"),
                                   RW'("Username?"), RW'("Password?"), RW'("Perms?"),
                                   RW'("Cmd?"), RW'("Username?"), RW'("Cmd?")};

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [RW-1:0] act,
                                input logic [RW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void chk_i(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Responder: answers the k-th strobe two cycles later, optionally corrupting one step.
    int            flt_step;
    logic [RW-1:0] flt_val;
    int            rsp_cnt_a, rsp_cnt_b;
    logic          rdy_d_a, rdy_d_b;

    function automatic logic [RW-1:0] respond(input int idx);
        if (idx == flt_step) return flt_val;
        if (idx >= 0 && idx < 9) return rsp_tab[idx];
        return '0;
    endfunction

    always @(posedge clk) begin
        if (rsp_clr) begin
            rsp_cnt_a <= 0;
            rsp_cnt_b <= 0;
            rdy_d_a   <= 1'b0;
            rdy_d_b   <= 1'b0;
            shop_a_a  <= '0;
            shop_a_b  <= '0;
        end else begin
            rdy_d_a <= rdy_a;
            rdy_d_b <= rdy_b;
            if (rdy_d_a) begin
                shop_a_a  <= respond(rsp_cnt_a);
                rsp_cnt_a <= rsp_cnt_a + 1;
            end
            if (rdy_d_b) begin
                shop_a_b  <= respond(rsp_cnt_b);
                rsp_cnt_b <= rsp_cnt_b + 1;
            end
        end
    end

    // Script-level model: the run ends at the first corrupted step, each step lasts a fixed span.
    task automatic ref_run(input int fk, input int s, input int w, input int g,
                           output bit p, output logic [3:0] fs, output int ns, output int de);
        int last;
        int span;
        bit faulted;
        faulted = (fk >= 0 && fk <= 8);
        last    = faulted ? fk : 8;
        span    = s + 1 + w + 1 + g;
        ns      = last + 1;
        de      = span * last + s + w + 2;
        p       = !faulted;
        fs      = faulted ? 4'(fk) : 4'hF;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " rdy"},  RW'(obs_rdy),  RW'(0));
        chk({tag, " u"},    RW'(obs_u),    RW'(0));
        chk({tag, " a"},    RW'(obs_a),    RW'(0));
        chk({tag, " busy"}, RW'(obs_busy), RW'(0));
        chk({tag, " done"}, RW'(obs_done), RW'(0));
        chk({tag, " pass"}, RW'(obs_pass), RW'(0));
        chk({tag, " fail"}, RW'(obs_fail), RW'(4'hF));
        chk({tag, " step"}, RW'(obs_step), RW'(0));
    endtask

    task automatic run(input bit s, input int fk, input logic [RW-1:0] fv, input bit hold,
                       input bit exp_pass, input logic [3:0] exp_fail, input int exp_ns,
                       input int exp_done, input int st, input int wt, input int gp,
                       input string tag);
        int se, r, ns, done_r, stable, span;
        logic [AW-1:0] prev_a;
        bit got;
        sel      = s;
        flt_step = fk;
        flt_val  = fv;
        @(negedge clk) rsp_clr = 1'b1;
        @(negedge clk) rsp_clr = 1'b0;
        prev_a = obs_a;
        stable = 0;
        if (s) start_b = 1'b1;
        else start_a = 1'b1;
        se     = int'(cyc) + 1;
        span   = st + 1 + wt + 1 + gp;
        ns     = 0;
        got    = 1'b0;
        done_r = -1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            r = int'(cyc) - se;
            if (!hold) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if (obs_a == prev_a) stable++;
            else stable = 1;
            prev_a = obs_a;
            if (r == 0) chk({tag, " busy at start"}, RW'(obs_busy), RW'(1));
            if (obs_rdy) begin
                if (ns < 9) begin
                    chk({tag, " strobe cmd"}, RW'(obs_a), RW'(cmd_tab[ns]));
                    chk_i({tag, " strobe edge"}, r, span * ns + st);
                    chk_i({tag, " strobe step"}, int'(obs_step), ns);
                    chk_i({tag, " cmd setup hold"}, int'(stable >= st + 1), 1);
                end
                ns++;
            end
            if (obs_done) begin
                got    = 1'b1;
                done_r = r;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: done never rose, expected at edge %0d", tag, exp_done);
        end
        chk_i({tag, " done edge"}, done_r, exp_done);
        chk_i({tag, " strobes"}, ns, exp_ns);
        chk({tag, " pass"}, RW'(obs_pass), RW'(exp_pass));
        chk({tag, " fail_step"}, RW'(obs_fail), RW'(exp_fail));
        chk({tag, " busy at done"}, RW'(obs_busy), RW'(0));
    endtask

    typedef struct {
        int            fk;
        logic [RW-1:0] fv;
        bit            exp_pass;
        logic [3:0]    exp_fail;
        int            exp_ns;
        int            exp_done;
    } vec_t;

    initial begin
        vec_t          vecs [5];
        int            fk, mode, ns, de, cnt;
        bit            p;
        logic [3:0]    fs;
        logic [RW-1:0] fv;

        vecs[0] = '{-1, '0, 1'b1, 4'hF, 9, 71};
        vecs[1] = '{1, RW'("Cmd?"), 1'b0, 4'd1, 2, 15};
        vecs[2] = '{5, RW'("Perms"), 1'b0, 4'd5, 6, 47};
        vecs[3] = '{0, RW'("Password?"), 1'b0, 4'd0, 1, 7};
        vecs[4] = '{8, RW'("Username?"), 1'b0, 4'd8, 9, 71};

        rst      = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        rsp_clr  = 1'b1;
        sel      = 1'b0;
        flt_step = -1;
        flt_val  = '0;
        repeat (3) @(negedge clk);
        chk_reset("reset a");
        sel = 1'b1;
        #1 chk_reset("reset b");
        sel     = 1'b0;
        rst     = 1'b0;
        rsp_clr = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run(1'b0, vecs[i].fk, vecs[i].fv, 1'b0, vecs[i].exp_pass, vecs[i].exp_fail,
                vecs[i].exp_ns, vecs[i].exp_done, 1, 4, 1, $sformatf("vec%0d", i));
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d done held", i), RW'(done_a), RW'(1));
        end

        for (int i = 0; i < 12; i++) begin
            fk = int'($urandom_range(0, 9));
            if (fk == 9) fk = -1;
            mode = int'($urandom_range(0, 2));
            if (mode == 0) fv = rsp_tab[$urandom_range(0, 8)];
            else if (mode == 1) fv = {8'($urandom), $urandom, $urandom};
            else fv = rsp_tab[(fk < 0) ? 0 : fk] ^ (RW'(1) << $urandom_range(0, RW - 1));
            if (fk >= 0 && fv == rsp_tab[fk]) fv[0] = ~fv[0];
            ref_run(fk, 1, 4, 1, p, fs, ns, de);
            run(1'b0, fk, fv, 1'b0, p, fs, ns, de, 1, 4, 1, $sformatf("rand%0d", i));
        end

        ref_run(-1, 3, 1, 2, p, fs, ns, de);
        run(1'b1, -1, '0, 1'b0, p, fs, ns, de, 3, 1, 2, "alt timing");
        sel = 1'b0;

        // Reset during the step-4 response wait, then a clean replay.
        flt_step = -1;
        @(negedge clk) rsp_clr = 1'b1;
        @(negedge clk) rsp_clr = 1'b0;
        start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (34) @(negedge clk);
        rst = 1'b1;
        chk("rdy during reset", RW'(rdy_a), RW'(0));
        @(negedge clk);
        chk_reset("mid-run reset");
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rdy_a) cnt++;
        end
        chk_i("strobes after reset", cnt, 0);
        chk("done after reset", RW'(done_a), RW'(0));
        run(1'b0, -1, '0, 1'b0, 1'b1, 4'hF, 9, 71, 1, 4, 1, "replay");

        // Start held high for a whole run, then an immediate restart from DONE.
        run(1'b0, -1, '0, 1'b1, 1'b1, 4'hF, 9, 71, 1, 4, 1, "held start");
        @(negedge clk);
        chk("restart done", RW'(done_a), RW'(0));
        chk("restart busy", RW'(busy_a), RW'(1));
        chk("restart pass", RW'(pass_a), RW'(0));
        chk("restart fail_step", RW'(fail_a), RW'(4'hF));
        chk("restart step", RW'(step_a), RW'(0));
        @(negedge clk);
        chk("restart strobe", RW'(rdy_a), RW'(1));
        chk("restart cmd", RW'(a_a), RW'(cmd_tab[0]));
        rst = 1'b1;
        #1 chk("strobe gated by reset", RW'(rdy_a), RW'(0));
        start_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("busy after final reset", RW'(busy_a), RW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
